// File: rtl/mrs_pkg.sv
// Shared definitions for the masking rotating shifter (mrs_pipe).
// Holds the operation mode encodings, the mode-legality check and
// the width of the sideband bus that travels down the rotate stages.
package mrs_pkg;

    typedef logic [2:0] mrs_mode_t;

    localparam mrs_mode_t MRS_ROR = 3'b000;
    localparam mrs_mode_t MRS_ROL = 3'b001;
    localparam mrs_mode_t MRS_SRL = 3'b010;
    localparam mrs_mode_t MRS_SLL = 3'b011;
    localparam mrs_mode_t MRS_SRA = 3'b100;

    // Encodings above MRS_SRA are reserved and flagged as errors.
    function automatic logic mrs_is_legal(input mrs_mode_t mode);
        return (mode <= MRS_SRA);
    endfunction

    // Sideband layout, MSB first: {mask, fill, co, err, tag, r}.
    function automatic int unsigned mrs_side_w(input int unsigned width,
                                               input int unsigned tag_w);
        return 2 * width + 2 + tag_w + $clog2(width);
    endfunction

endpackage

// File: rtl/mrs_if.sv
// Handshake bundle for mrs_pipe.
//   in_valid/in_ready  : operation request handshake
//   in_data/amt/mode/tag : operand, shift amount, mode, sideband tag
//   out_valid/out_ready: result handshake
//   out_data/co/err/tag: result, last bit shifted out, illegal-mode flag, tag
// Modports: master = environment driving requests and consuming results,
//           slave  = the shifter pipeline.
interface mrs_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
);
    import mrs_pkg::*;

    localparam int unsigned SW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SW-1:0]    in_amt;
    mrs_mode_t        in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_co;
    logic             out_err;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_co, out_err, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_co, out_err, out_tag
    );

endinterface

// File: rtl/mrs_rot_stage.sv
// One registered stage of the rotate network: rotates the word right by
// DIST when the matching bit of the effective amount r is set, and carries
// the sideband bus {mask, fill, co, err, tag, r} alongside unchanged.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   en                   pipeline advance; registers hold when low
//   in_valid/data/side   previous stage
//   out_valid/data/side  registered result
module mrs_rot_stage #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DIST   = 1,
    parameter int unsigned SIDE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic [SIDE_W-1:0] out_side
);

    // r sits in the low bits of the sideband, so bit log2(DIST) selects this stage.
    localparam int unsigned RBIT = $clog2(DIST);

    logic [WIDTH-1:0]  rot;
    logic              valid_q;
    logic [WIDTH-1:0]  data_q;
    logic [SIDE_W-1:0] side_q;

    always_comb begin
        rot = in_data;
        if (in_side[RBIT]) begin
            rot = (in_data >> DIST) | (in_data << (WIDTH - DIST));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            side_q  <= '0;
        end else if (en) begin
            valid_q <= in_valid;
            data_q  <= rot;
            side_q  <= in_side;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_side  = side_q;

endmodule

// File: rtl/mrs_pipe.sv
// Pipelined masking rotating shifter. ROR/ROL/SRL/SLL/SRA on a WIDTH-bit
// word built from one right rotator (SW registered stages), a mask and a
// sign fill. Latency SW+1, one op per cycle, whole pipe stalls together.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   bus         mrs_if slave: request handshake in, result handshake out
module mrs_pipe
    import mrs_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) (
    input logic   clk,
    input logic   rst_n,
    mrs_if.slave  bus
);

    localparam int unsigned SW     = $clog2(WIDTH);
    localparam int unsigned SIDE_W = mrs_side_w(WIDTH, TAG_W);

    logic              advance;
    logic              legal;
    logic [SW-1:0]     neg_amt;
    logic [SW-1:0]     amt_m1;
    logic [SW-1:0]     r_d;
    logic [WIDTH-1:0]  mask_d;
    logic [WIDTH-1:0]  fill_d;
    logic              co_d;

    logic              s0_valid_q;
    logic [WIDTH-1:0]  s0_data_q;
    logic [SIDE_W-1:0] s0_side_q;

    logic              valid_s [SW+1];
    logic [WIDTH-1:0]  data_s  [SW+1];
    logic [SIDE_W-1:0] side_s  [SW+1];

    logic [WIDTH-1:0]  o_mask;
    logic [WIDTH-1:0]  o_fill;
    logic              o_co;
    logic              o_err;
    logic [TAG_W-1:0]  o_tag;
    logic [SW-1:0]     unused_r;

    // Every stage moves in lock-step; a stalled output freezes the whole pipe.
    assign advance      = !valid_s[SW] || bus.out_ready;
    assign bus.in_ready = rst_n && advance;

    // Stage 0 decode: left operations become right rotates by (WIDTH - amt) mod WIDTH.
    always_comb begin
        legal   = mrs_is_legal(bus.in_mode);
        neg_amt = '0 - bus.in_amt;
        amt_m1  = bus.in_amt - SW'(1);
        r_d     = bus.in_amt;
        if (bus.in_mode == MRS_ROL || bus.in_mode == MRS_SLL) begin
            r_d = neg_amt;
        end

        mask_d = '1;
        case (bus.in_mode)
            MRS_SRL, MRS_SRA: mask_d = {WIDTH{1'b1}} >> bus.in_amt;
            MRS_SLL:          mask_d = {WIDTH{1'b1}} << bus.in_amt;
            default:          mask_d = '1;
        endcase

        fill_d = '0;
        if (bus.in_mode == MRS_SRA && bus.in_data[WIDTH-1]) begin
            fill_d = ~mask_d;
        end

        co_d = 1'b0;
        if (bus.in_amt != '0) begin
            case (bus.in_mode)
                MRS_SRL, MRS_SRA: co_d = bus.in_data[amt_m1];
                MRS_SLL:          co_d = bus.in_data[neg_amt];
                default:          co_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q <= 1'b0;
            s0_data_q  <= '0;
            s0_side_q  <= '0;
        end else if (advance) begin
            s0_valid_q <= bus.in_valid;
            s0_data_q  <= bus.in_data;
            s0_side_q  <= {mask_d, fill_d, co_d, !legal, bus.in_tag, r_d};
        end
    end

    assign valid_s[0] = s0_valid_q;
    assign data_s[0]  = s0_data_q;
    assign side_s[0]  = s0_side_q;

    for (genvar i = 1; i <= SW; i++) begin : g_stage
        mrs_rot_stage #(
            .WIDTH  (WIDTH),
            .DIST   (1 << (i - 1)),
            .SIDE_W (SIDE_W)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (advance),
            .in_valid  (valid_s[i-1]),
            .in_data   (data_s[i-1]),
            .in_side   (side_s[i-1]),
            .out_valid (valid_s[i]),
            .out_data  (data_s[i]),
            .out_side  (side_s[i])
        );
    end

    // r has been consumed by the rotate network and is dropped here.
    assign {o_mask, o_fill, o_co, o_err, o_tag, unused_r} = side_s[SW];

    assign bus.out_valid = valid_s[SW];
    assign bus.out_data  = o_err ? '0 : ((data_s[SW] & o_mask) | o_fill);
    assign bus.out_co    = o_co;
    assign bus.out_err   = o_err;
    assign bus.out_tag   = o_tag;

endmodule
